// File: rtl/macc_collect_pkg.sv
// rtl/macc_collect_pkg.sv - shared types for the hls_macc_nb result collector
package macc_collect_pkg;

  localparam int NUM_OUT = 4;
  localparam int RES_DW  = 32;

  typedef struct packed {
    logic [NUM_OUT-1:0][RES_DW-1:0] data;
    logic [NUM_OUT-1:0]             mask;
  } res_t;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_t;

endpackage

// File: rtl/macc_collect_fifo.sv
// rtl/macc_collect_fifo.sv - synchronous show-ahead FIFO with push/pop/count
module macc_collect_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic          push_ok,
  output logic [PW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          pop_ok;

  // Extra pointer MSB tells full (same index, different lap) from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = wr_ptr - rd_ptr;
  assign valid   = !empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/macc_nb_result_collector.sv
// rtl/macc_nb_result_collector.sv - collects hls_macc_nb o1..o4 results into a streamed FIFO
// Optional MACC_COLLECT_SEQ_EN adds a 16-bit per-result sequence number on m_seq.
module macc_nb_result_collector
  import macc_collect_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DW-1:0]     o1,
  input  logic [DW-1:0]     o2,
  input  logic [DW-1:0]     o3,
  input  logic [DW-1:0]     o4,
  input  logic              o1_ap_vld,
  input  logic              o2_ap_vld,
  input  logic              o3_ap_vld,
  input  logic              o4_ap_vld,
  input  logic              ap_done,
  output logic              start_ok,
  output logic [4*DW-1:0]   m_data,
  output logic [3:0]        m_mask,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef MACC_COLLECT_SEQ_EN
  output logic [15:0]       m_seq,
`endif
  output logic              dup_err,
  output logic              ovf_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] START_LIM = CW'(DEPTH - 1);

  state_t                         state_q, state_nx;
  logic [NUM_OUT-1:0][DW-1:0]     in_w;
  logic [NUM_OUT-1:0]             vld;
  logic [NUM_OUT-1:0][DW-1:0]     slot_q, slot_cl;
  logic [NUM_OUT-1:0]             mask_q, mask_cl;
  logic                           pop;
  logic                           push_ok;
  logic [CW-1:0]                  count, cnt_nx;

  assign in_w = {o4, o3, o2, o1};
  assign vld  = {o4_ap_vld, o3_ap_vld, o2_ap_vld, o1_ap_vld};

  // Closing view: strobes arriving with ap_done are folded into the pushed result.
  always_comb begin
    slot_cl = slot_q;
    mask_cl = mask_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (vld[k]) begin
        slot_cl[k] = in_w[k];
        mask_cl[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    if (ap_done)    state_nx = ST_IDLE;
    else if (|vld)  state_nx = ST_COLLECT;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      mask_q  <= '0;
      dup_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (ap_done) begin
        slot_q <= '0;
        mask_q <= '0;
      end else begin
        slot_q <= slot_cl;
        mask_q <= mask_cl;
      end
      if (|(vld & mask_q))    dup_err <= 1'b1;
      if (ap_done && !push_ok) ovf_err <= 1'b1;
    end
  end

`ifdef MACC_COLLECT_SEQ_EN
  localparam int EW = NUM_OUT*DW + NUM_OUT + 16;
  logic [15:0]   seq_q;
  logic [EW-1:0] fifo_din, fifo_dout;
  assign fifo_din = {seq_q, slot_cl, mask_cl};
  assign {m_seq, m_data, m_mask} = fifo_dout;

  always_ff @(posedge ap_clk) begin
    if (ap_rst)       seq_q <= '0;
    else if (push_ok) seq_q <= seq_q + 16'd1;
  end
`else
  localparam int EW = NUM_OUT*DW + NUM_OUT;
  logic [EW-1:0] fifo_din, fifo_dout;
  assign fifo_din = {slot_cl, mask_cl};
  assign {m_data, m_mask} = fifo_dout;
`endif

  assign pop = m_valid && m_ready;

  macc_collect_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .push    (ap_done),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .valid   (m_valid),
    .push_ok (push_ok),
    .count   (count)
  );

  // Registered from the post-edge count so start_ok tracks occupancy without lag.
  assign cnt_nx = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) start_ok <= 1'b1;
    else        start_ok <= (cnt_nx < START_LIM);
  end

endmodule

// File: doc/macc_nb_result_collector.md
# macc_nb_result_collector

Downstream consumer of the `hls_macc_nb` core. It captures the four independently-strobed results (`o1`..`o4` with their `_ap_vld` pulses) of each core invocation and closes the result on the core's `ap_done`. Each closed result is packed with a validity mask into a small FIFO, and the FIFO drains over a valid/ready stream. It also drives a start-permission signal so the launcher never starts the core when there is no room for the result.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries, power of two, ≥2.
- `DW`, 32 — width of each result word.

Ports:
- `ap_clk`, in, 1 — sole clock.
- `ap_rst`, in, 1 — reset. Synchronous and active-high.
- `o1`..`o4`, in, DW each — result words from the core.
- `o1_ap_vld`..`o4_ap_vld`, in, 1 each — single-cycle capture strobes.
- `ap_done`, in, 1 — end of core invocation; closes the current result.
- `start_ok`, out, 1 — launcher may assert core `ap_start`.
- `m_data`, out, 4*DW — packed result `{o4,o3,o2,o1}`.
- `m_mask`, out, 4 — bit k set if `o(k+1)` was strobed during this invocation.
- `m_valid`, out, 1 — output stream valid.
- `m_ready`, in, 1 — output stream ready.
- `dup_err`, out, 1 — sticky; a slot was strobed twice in one invocation.
- `ovf_err`, out, 1 — sticky; `ap_done` arrived while the FIFO was full and no pop was occurring.

## Operation
- FSM states:
  - IDLE: no slot captured.
  - COLLECT: at least one slot captured.
- Transitions:
  - IDLE→COLLECT on any `_ap_vld`.
  - Any state→IDLE on `ap_done`.
- Capture:
  - `ok_ap_vld` writes slot k and sets mask bit k.
  - A slot already set is overwritten (last wins) and `dup_err` sets.
  - A strobe in the same cycle as `ap_done` is included in the closing result.
- Close:
  - On `ap_done`, push `{slots, mask}` into the FIFO.
  - Unstrobed slots are pushed as 0.
  - Slot registers and mask clear on the next cycle.
  - `ap_done` with an empty mask still pushes (mask 0000).
- Push acceptance: accepted if FIFO count < DEPTH, or if count == DEPTH with a pop in the same cycle. Otherwise the result is dropped and `ovf_err` sets.
- Pop occurs when `m_valid && m_ready`.
- `start_ok` = (count < DEPTH-1), registered. This permits exactly one outstanding invocation.
- Error flags clear only on reset.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_mask`=0.
  - `start_ok`=1, `dup_err`=0, `ovf_err`=0.
  - FSM=IDLE, FIFO empty.
- Latency: `ap_done` in cycle N → `m_valid`=1 in cycle N+1 (FIFO was empty).
- Stream rules:
  - `m_data`/`m_mask` are held stable while `m_valid && !m_ready`.
  - `m_valid` does not depend combinationally on `m_ready`.
- Simultaneous push and pop on an empty FIFO: no bypass. The pushed entry appears at N+1.
- Full FIFO: push with a simultaneous pop is accepted. Count is unchanged and order is preserved.
- Wrap-around: pointers are log2(DEPTH)+1 bits. Full/empty is derived from the MSB difference.
- Reset mid-collect: partial slots are discarded and the FIFO is flushed within the same clock edge.

## Configuration
- `MACC_COLLECT_SEQ_EN`
  - Defined: adds output `m_seq` [15:0], a per-pushed-result sequence number. It is 0 after reset, increments per accepted push, and wraps 0xFFFF→0. Dropped results do not consume a number.
  - Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package `macc_collect_pkg`:
  - `NUM_OUT`=4.
  - `res_t` struct `{data[NUM_OUT][DW], mask[NUM_OUT]}`.
  - State enum `{ST_IDLE, ST_COLLECT}`.
- Sub-module `macc_collect_fifo`: synchronous show-ahead FIFO with push/pop/count. Width and depth are parameterized.

## Test plan
- Strobe o1=0x11, o2=0x22, o3=0x33, o4=0x44 in separate cycles, then `ap_done` → one beat: `m_data`=0x00000044_00000033_00000022_00000011, `m_mask`=1111, `m_valid` rises one cycle after `ap_done`.
- Strobe only o2=0xAB, with `ap_done` in the same cycle as the strobe → `m_mask`=0010, o2 slot=0xAB, other slots 0.
- Strobe o3=5 then o3=7 before `ap_done` → o3 slot=7, `dup_err`=1 and stays 1 until `ap_rst`.
- `m_ready`=0, five `ap_done` with DEPTH=4 → four beats held, fifth dropped, `ovf_err`=1. `start_ok`=0 once count reaches 3. After release, drain order matches push order.
- FIFO full, `ap_done` coinciding with a pop → no overflow, count stays 4, new result emerges last.
- `ap_rst` asserted mid-COLLECT with 2 entries queued → next cycle `m_valid`=0, `start_ok`=1, flags 0. The next invocation yields an exact result with no stale slots.
